// File: rtl/ctrl_fsm_pkg.sv
// Shared encodings for the RV32I multi-cycle control sequencer: opcodes,
// mux selects, trap causes and FSM states.
package ctrl_fsm_pkg;

  // insn[6:2] major opcodes
  localparam logic [4:0] OP_LOAD     = 5'b00000;
  localparam logic [4:0] OP_MISC_MEM = 5'b00011;
  localparam logic [4:0] OP_ALUIMM   = 5'b00100;
  localparam logic [4:0] OP_AUIPC    = 5'b00101;
  localparam logic [4:0] OP_STORE    = 5'b01000;
  localparam logic [4:0] OP_ALU      = 5'b01100;
  localparam logic [4:0] OP_LUI      = 5'b01101;
  localparam logic [4:0] OP_BRANCH   = 5'b11000;
  localparam logic [4:0] OP_JALR     = 5'b11001;
  localparam logic [4:0] OP_JAL      = 5'b11011;
  localparam logic [4:0] OP_SYSTEM   = 5'b11100;

  localparam logic [1:0] PC_SEL_PC4  = 2'b00;
  localparam logic [1:0] PC_SEL_IMM  = 2'b01;
  localparam logic [1:0] PC_SEL_JALR = 2'b10;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_MEM  = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;
  localparam logic [1:0] WB_SEL_IMM  = 2'b11;

  localparam logic [1:0] TRAP_ILLEGAL = 2'b00;
  localparam logic [1:0] TRAP_SYSTEM  = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_TRAP   = 3'd4
  } state_t;

  // SYSTEM is deliberately absent: it traps with its own cause.
  function automatic logic is_legal_op(input logic [4:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_ALUIMM, OP_ALU, OP_MISC_MEM: is_legal_op = 1'b1;
      default:                                           is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_timeout.sv
// Memory-wait watchdog: counts stalled request cycles and flags the last
// allowed one. MEM_TIMEOUT = 0 disables it.
module ctrl_timeout #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TMO_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic cnt,
  output logic expired
);

  logic [TMO_W-1:0] tmo;

  always_ff @(posedge clk) begin
    if (rst || clr)
      tmo <= '0;
    else if (cnt)
      tmo <= tmo + 1'b1;
  end

  if (MEM_TIMEOUT == 0) begin : g_off
    assign expired = 1'b0;
  end else begin : g_on
    assign expired = (tmo == TMO_W'(MEM_TIMEOUT - 1));
  end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH -> DECODE -> EXEC [-> MEM],
// driving datapath strobes and a shared valid/ready memory port; sticky trap.
module ctrl_fsm
  import ctrl_fsm_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TMO_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] opcode,
  input  logic       invalid,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       mem_valid,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       alu_a_sel,
  output logic       alu_b_sel,
  output logic       alu_add,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic       trap,
  output logic [1:0] trap_cause
);

  state_t     state;
  logic [4:0] op_q;
  logic       trap_q;
  logic [1:0] cause_q;
  logic       tmo_exp;
  logic       waiting;

  // Any cycle not stalled on memory restarts the count, which covers
  // entry into FETCH and MEM as well as completed transfers.
  assign waiting = mem_valid && !mem_ready;

  ctrl_timeout #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TMO_W      (TMO_W)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (!waiting),
    .cnt    (waiting),
    .expired(tmo_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_FETCH;
      op_q    <= '0;
      trap_q  <= 1'b0;
      cause_q <= TRAP_ILLEGAL;
    end else begin
      case (state)
        ST_FETCH, ST_MEM: begin
          // mem_ready wins over a same-cycle timeout
          if (mem_ready)
            state <= (state == ST_FETCH) ? ST_DECODE : ST_FETCH;
          else if (tmo_exp) begin
            state   <= ST_TRAP;
            trap_q  <= 1'b1;
            cause_q <= TRAP_TIMEOUT;
          end
        end
        ST_DECODE: begin
          op_q <= opcode;
          if (invalid || (!is_legal_op(opcode) && opcode != OP_SYSTEM)) begin
            state   <= ST_TRAP;
            trap_q  <= 1'b1;
            cause_q <= TRAP_ILLEGAL;
          end else if (opcode == OP_SYSTEM) begin
            state   <= ST_TRAP;
            trap_q  <= 1'b1;
            cause_q <= TRAP_SYSTEM;
          end else
            state <= ST_EXEC;
        end
        ST_EXEC:
          state <= (op_q == OP_LOAD || op_q == OP_STORE) ? ST_MEM : ST_FETCH;
        ST_TRAP: state <= ST_TRAP;
        default: state <= ST_FETCH;
      endcase
    end
  end

  assign trap       = trap_q;
  assign trap_cause = cause_q;

  always_comb begin
    mem_valid    = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_SEL_PC4;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    alu_add      = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = WB_SEL_ALU;
    retire       = 1'b0;
    if (!rst) begin
      case (state)
        ST_FETCH: begin
          mem_valid = 1'b1;
          ir_we     = mem_ready;
        end
        ST_EXEC: begin
          case (op_q)
            OP_ALU, OP_ALUIMM: begin
              alu_b_sel = (op_q == OP_ALUIMM);
              rf_we     = 1'b1;
              pc_we     = 1'b1;
              retire    = 1'b1;
            end
            OP_LUI: begin
              rf_we  = 1'b1;
              wb_sel = WB_SEL_IMM;
              pc_we  = 1'b1;
              retire = 1'b1;
            end
            OP_AUIPC: begin
              alu_a_sel = 1'b1;
              alu_b_sel = 1'b1;
              alu_add   = 1'b1;
              rf_we     = 1'b1;
              pc_we     = 1'b1;
              retire    = 1'b1;
            end
            OP_JAL, OP_JALR: begin
              rf_we  = 1'b1;
              wb_sel = WB_SEL_PC4;
              pc_we  = 1'b1;
              pc_sel = (op_q == OP_JAL) ? PC_SEL_IMM : PC_SEL_JALR;
              retire = 1'b1;
            end
            OP_BRANCH: begin
              pc_we  = 1'b1;
              pc_sel = br_taken ? PC_SEL_IMM : PC_SEL_PC4;
              retire = 1'b1;
            end
            OP_MISC_MEM: begin
              pc_we  = 1'b1;
              retire = 1'b1;
            end
            OP_LOAD, OP_STORE: begin
              alu_b_sel = 1'b1;
              alu_add   = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          // address operands held so mem_addr stays stable until ready
          mem_valid    = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (op_q == OP_STORE);
          alu_b_sel    = 1'b1;
          alu_add      = 1'b1;
          if (mem_ready) begin
            rf_we  = (op_q == OP_LOAD);
            wb_sel = (op_q == OP_LOAD) ? WB_SEL_MEM : WB_SEL_ALU;
            pc_we  = 1'b1;
            retire = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
